// File: rtl/main_dsp48a1.sv
// DSP48A1-style slice: 18-bit pre-adder, 18x18 multiplier, 48-bit post-adder/accumulator, per-stage bypass.
// Build option: define MAIN_DSP48A1_BCASCADE_EN to let B_INPUT="CASCADE" route BCIN into the B path.
module main_dsp48a1 #(
    parameter int    width1      = 18,
    parameter int    width2      = 48,
    parameter int    width3      = 8,
    parameter int    width4      = 36,
    parameter int    width5      = 1,
    parameter int    A0REG       = 0,
    parameter int    A1REG       = 1,
    parameter int    B0REG       = 0,
    parameter int    B1REG       = 1,
    parameter int    CREG        = 1,
    parameter int    DREG        = 1,
    parameter int    MREG        = 1,
    parameter int    PREG        = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    CARRYOUTREG = 1,
    parameter int    OPMODEREG   = 1,
    parameter string CARRYINSEL  = "OPMODE5",
    parameter string B_INPUT     = "DIRECT",
    parameter string RSTTYPE     = "SYNC"
) (
    input  logic              clk,
    input  logic              RSTA,
    input  logic              RSTB,
    input  logic              RSTC,
    input  logic              RSTD,
    input  logic              RSTM,
    input  logic              RSTP,
    input  logic              RSTOPMODE,
    input  logic              RSTCARRYIN,
    input  logic              CEA,
    input  logic              CEB,
    input  logic              CEC,
    input  logic              CED,
    input  logic              CEM,
    input  logic              CEP,
    input  logic              CEOPMODE,
    input  logic              CECARRYIN,
    input  logic [width1-1:0] A,
    input  logic [width1-1:0] B,
    input  logic [width1-1:0] D,
    input  logic [width2-1:0] C,
    input  logic [width1-1:0] BCIN,
    input  logic [width2-1:0] PCIN,
    input  logic [width3-1:0] OPMODE,
    input  logic [width5-1:0] CARRYIN,
    output logic [width2-1:0] P,
    output logic [width2-1:0] PCOUT,
    output logic [width4-1:0] M,
    output logic [width1-1:0] BCOUT,
    output logic [width5-1:0] CARRYOUT,
    output logic [width5-1:0] CARRYOUTF
);

    localparam bit CIN_FROM_OPM  = (CARRYINSEL == "OPMODE5");
    localparam bit CIN_FROM_PORT = (CARRYINSEL == "CARRYIN");
`ifdef MAIN_DSP48A1_BCASCADE_EN
    localparam bit B_FROM_PORT   = (B_INPUT == "DIRECT");
    localparam bit B_FROM_CASC   = (B_INPUT == "CASCADE");
`else
    localparam bit B_FROM_PORT   = 1'b1;
    localparam bit B_FROM_CASC   = 1'b0;
`endif

    logic [width1-1:0] r_a0, r_a1, r_b0, r_b1, r_d;
    logic [width2-1:0] r_c, r_p;
    logic [width4-1:0] r_m;
    logic [width3-1:0] r_opm;
    logic [width5-1:0] r_cyi, r_cyo;

    logic [width1-1:0] w_a0, w_a1, w_b_src, w_b0, w_b1, w_d, w_pre;
    logic [width2-1:0] w_c, w_p, w_x, w_z;
    logic [width4-1:0] w_mult, w_m;
    logic [width3-1:0] w_opm;
    logic [width5-1:0] w_cyi_src, w_cin, w_cyo;
    logic [width2:0]   w_x_ext, w_z_ext, w_cin_ext, w_post;

    // Input stage: source selection and first-level registers
    assign w_b_src   = B_FROM_PORT ? B : (B_FROM_CASC ? BCIN : '0);
    assign w_a0      = (A0REG == 1) ? r_a0 : A;
    assign w_a1      = (A1REG == 1) ? r_a1 : w_a0;
    assign w_b0      = (B0REG == 1) ? r_b0 : w_b_src;
    assign w_d       = (DREG == 1) ? r_d : D;
    assign w_c       = (CREG == 1) ? r_c : C;
    assign w_opm     = (OPMODEREG == 1) ? r_opm : OPMODE;
    assign w_cyi_src = CIN_FROM_OPM ? width5'(w_opm[5]) : (CIN_FROM_PORT ? CARRYIN : '0);
    assign w_cin     = (CARRYINREG == 1) ? r_cyi : w_cyi_src;

    always_ff @(posedge clk) begin
        if (RSTA) begin
            r_a0 <= '0;
            r_a1 <= '0;
        end else if (CEA) begin
            r_a0 <= A;
            r_a1 <= w_a0;
        end
    end

    always_ff @(posedge clk) begin
        if (RSTB) begin
            r_b0 <= '0;
            r_b1 <= '0;
        end else if (CEB) begin
            r_b0 <= w_b_src;
            r_b1 <= w_pre;
        end
    end

    always_ff @(posedge clk) begin
        if (RSTC)     r_c <= '0;
        else if (CEC) r_c <= C;
    end

    always_ff @(posedge clk) begin
        if (RSTD)     r_d <= '0;
        else if (CED) r_d <= D;
    end

    always_ff @(posedge clk) begin
        if (RSTOPMODE)     r_opm <= '0;
        else if (CEOPMODE) r_opm <= OPMODE;
    end

    always_ff @(posedge clk) begin
        if (RSTCARRYIN)     r_cyi <= '0;
        else if (CECARRYIN) r_cyi <= w_cyi_src;
    end

    // Pre-adder stage feeding B1
    always_comb begin
        w_pre = w_b0;
        if (w_opm[4]) begin
            w_pre = w_opm[6] ? (w_d - w_b0) : (w_d + w_b0);
        end
    end

    assign w_b1  = (B1REG == 1) ? r_b1 : w_pre;
    assign BCOUT = w_b1;

    // Multiplier stage
    assign w_mult = width4'(w_a1) * width4'(w_b1);
    assign w_m    = (MREG == 1) ? r_m : w_mult;
    assign M      = w_m;

    always_ff @(posedge clk) begin
        if (RSTM)     r_m <= '0;
        else if (CEM) r_m <= w_mult;
    end

    // Post-adder stage: X/Z operand muxes, 49-bit add/subtract, P and carry registers
    always_comb begin
        w_x = '0;
        case (w_opm[1:0])
            2'b01:   w_x = {{(width2-width4){1'b0}}, w_m};
            2'b10:   w_x = w_p;
            2'b11:   w_x = {w_d[width2-2*width1-1:0], w_a1, w_b1};
            default: w_x = '0;
        endcase
    end

    always_comb begin
        w_z = '0;
        case (w_opm[3:2])
            2'b01:   w_z = PCIN;
            2'b10:   w_z = w_p;
            2'b11:   w_z = w_c;
            default: w_z = '0;
        endcase
    end

    assign w_x_ext   = {1'b0, w_x};
    assign w_z_ext   = {1'b0, w_z};
    assign w_cin_ext = {{(width2+1-width5){1'b0}}, w_cin};
    // Bit width2 is the carry when adding and the borrow when subtracting
    assign w_post    = w_opm[7] ? (w_z_ext - (w_x_ext + w_cin_ext))
                                : (w_z_ext + w_x_ext + w_cin_ext);
    assign w_cyo     = width5'(w_post[width2]);

    always_ff @(posedge clk) begin
        if (RSTP) begin
            r_p   <= '0;
            r_cyo <= '0;
        end else if (CEP) begin
            r_p   <= w_post[width2-1:0];
            r_cyo <= w_cyo;
        end
    end

    assign w_p       = (PREG == 1) ? r_p : w_post[width2-1:0];
    assign P         = w_p;
    assign PCOUT     = w_p;
    assign CARRYOUT  = (CARRYOUTREG == 1) ? r_cyo : w_cyo;
    assign CARRYOUTF = CARRYOUT;

endmodule

// File: tb/tb_main_dsp48a1.sv
// Self-checking bench for main_dsp48a1 (default parameters): latency-based reference model plus directed vectors.
module tb_main_dsp48a1;
    localparam int NH = 1024;

    logic clk = 1'b0;
    logic RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTOPMODE, RSTCARRYIN;
    logic CEA, CEB, CEC, CED, CEM, CEP, CEOPMODE, CECARRYIN;
    logic [17:0] A, B, D, BCIN;
    logic [47:0] C, PCIN;
    logic [7:0]  OPMODE;
    logic        CARRYIN;
    logic [47:0] P, PCOUT;
    logic [35:0] M;
    logic [17:0] BCOUT;
    logic        CARRYOUT, CARRYOUTF;

    int n_pass = 0;
    int n_tot  = 0;
    int ek     = 0;
    int base   = 0;
    bit mvalid = 1'b0;

    // Input history per edge and model expectations after each edge
    logic [17:0] hA [NH], hB [NH], hD [NH];
    logic [47:0] hC [NH], hPC [NH];
    logic [7:0]  hO [NH];
    logic        hRP [NH];
    logic [17:0] eB1 [NH];
    logic [35:0] eM [NH];
    logic [47:0] eP [NH];
    logic        eCy [NH];

    logic [47:0] sv_p;
    logic [35:0] sv_m;
    logic [17:0] sv_b;
    logic        sv_cy;

    main_dsp48a1 dut (
        .clk(clk), .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD), .RSTM(RSTM), .RSTP(RSTP),
        .RSTOPMODE(RSTOPMODE), .RSTCARRYIN(RSTCARRYIN),
        .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED), .CEM(CEM), .CEP(CEP),
        .CEOPMODE(CEOPMODE), .CECARRYIN(CECARRYIN),
        .A(A), .B(B), .D(D), .C(C), .BCIN(BCIN), .PCIN(PCIN), .OPMODE(OPMODE), .CARRYIN(CARRYIN),
        .P(P), .PCOUT(PCOUT), .M(M), .BCOUT(BCOUT), .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got 0x%h, expected 0x%h (edge %0d)", name, act, exp, ek);
        else n_pass++;
    endtask

    function automatic logic [17:0] preadd(input logic [17:0] d, input logic [17:0] b, input logic [7:0] o);
        if (!o[4]) return b;
        return o[6] ? (d - b) : (d + b);
    endfunction

    task automatic set_rst(input bit v);
        {RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTOPMODE, RSTCARRYIN} = {8{v}};
    endtask

    task automatic set_ce(input bit v);
        {CEA, CEB, CEC, CED, CEM, CEP, CEOPMODE, CECARRYIN} = {8{v}};
    endtask

    task automatic rand_ce();
        {CEA, CEB, CEC, CED, CEM, CEP, CEOPMODE, CECARRYIN} = 8'($urandom());
    endtask

    task automatic rand_data();
        A = 18'($urandom()); B = 18'($urandom()); D = 18'($urandom()); BCIN = 18'($urandom());
        C = {16'($urandom()), 32'($urandom())};
        PCIN = {16'($urandom()), 32'($urandom())};
        OPMODE = 8'($urandom()); CARRYIN = 1'($urandom());
    endtask

    // Expected outputs after edge k, from operand latencies: D/OPMODE registered once before
    // the pre-adder, B1 one edge, M two edges, P sees X/Z/OPMODE one edge old and OPMODE[5] two.
    task automatic model_step();
        int k;
        bit full, others, allce;
        logic [17:0] d1, a1;
        logic [47:0] c1, x, z;
        logic [7:0]  o1, o2;
        logic [48:0] s;
        ek++;
        k = ek;
        hA[k] = A; hB[k] = B; hD[k] = D; hC[k] = C; hPC[k] = PCIN; hO[k] = OPMODE; hRP[k] = RSTP;
        full   = RSTA && RSTB && RSTC && RSTD && RSTM && RSTP && RSTOPMODE && RSTCARRYIN;
        others = RSTA || RSTB || RSTC || RSTD || RSTM || RSTOPMODE || RSTCARRYIN;
        allce  = CEA && CEB && CEC && CED && CEM && CEP && CEOPMODE && CECARRYIN;
        if (full) begin
            base = k; mvalid = 1'b1;
            eB1[k] = '0; eM[k] = '0; eP[k] = '0; eCy[k] = 1'b0;
        end else begin
            if (others || !allce) mvalid = 1'b0;
            if (mvalid) begin
                d1 = (k - 1 > base) ? hD[k-1] : '0;
                a1 = (k - 1 > base) ? hA[k-1] : '0;
                c1 = (k - 1 > base) ? hC[k-1] : '0;
                o1 = (k - 1 > base) ? hO[k-1] : '0;
                o2 = (k - 2 > base) ? hO[k-2] : '0;
                eB1[k] = preadd(d1, hB[k], o1);
                eM[k]  = 36'(a1) * 36'(eB1[k-1]);
                case (o1[1:0])
                    2'd0: x = '0;
                    2'd1: x = {12'd0, eM[k-1]};
                    2'd2: x = eP[k-1];
                    default: x = {d1[11:0], a1, eB1[k-1]};
                endcase
                case (o1[3:2])
                    2'd0: z = '0;
                    2'd1: z = hPC[k];
                    2'd2: z = eP[k-1];
                    default: z = c1;
                endcase
                if (o1[7]) s = {1'b0, z} - ({1'b0, x} + 49'(o2[5]));
                else       s = {1'b0, z} + {1'b0, x} + 49'(o2[5]);
                eP[k]  = hRP[k] ? 48'd0 : s[47:0];
                eCy[k] = hRP[k] ? 1'b0 : s[48];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Compare process: every cycle the model is in step with the DUT
    initial forever begin
        @(negedge clk);
        if (mvalid && ek > 0) begin
            chk("P", P, eP[ek]);
            chk("PCOUT", PCOUT, eP[ek]);
            chk("M", 48'(M), 48'(eM[ek]));
            chk("BCOUT", 48'(BCOUT), 48'(eB1[ek]));
            chk("CARRYOUT", 48'(CARRYOUT), 48'(eCy[ek]));
            chk("CARRYOUTF", 48'(CARRYOUTF), 48'(eCy[ek]));
        end
    end

    initial begin
        set_rst(1'b1); set_ce(1'b1); rand_data();
        for (int i = 0; i < 10; i++) begin
            rand_data(); rand_ce(); set_rst(1'b1);
            tick();
        end
        chk("rst_p", P, 48'd0);
        chk("rst_m", 48'(M), 48'd0);
        chk("rst_bcout", 48'(BCOUT), 48'd0);
        chk("rst_carryoutf", 48'(CARRYOUTF), 48'd0);

        set_rst(1'b0); set_ce(1'b1);
        A = 18'd20; B = 18'd10; C = 48'd350; D = 18'd25; PCIN = 48'd0; BCIN = 18'd0; CARRYIN = 1'b0;
        OPMODE = 8'hDD;
        for (int i = 0; i < 4; i++) tick();
        chk("dd_bcout", 48'(BCOUT), 48'hF);
        chk("dd_m", 48'(M), 48'h12C);
        chk("dd_p", P, 48'h32);
        chk("dd_pcout", PCOUT, 48'h32);
        chk("dd_carryout", 48'(CARRYOUT), 48'd0);

        OPMODE = 8'h10;
        for (int i = 0; i < 4; i++) tick();
        chk("10_bcout", 48'(BCOUT), 48'h23);
        chk("10_m", 48'(M), 48'h2BC);
        chk("10_p", P, 48'd0);

        OPMODE = 8'h0A; CARRYIN = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("0a_bcout", 48'(BCOUT), 48'hA);
        chk("0a_m", 48'(M), 48'hC8);
        chk("0a_p", P, 48'd0);
        chk("0a_carryoutf", 48'(CARRYOUTF), 48'd0);

        OPMODE = 8'hA7; A = 18'd5; B = 18'd6; D = 18'd25; PCIN = 48'd3000;
        for (int i = 0; i < 4; i++) tick();
        chk("a7_bcout", 48'(BCOUT), 48'd6);
        chk("a7_m", 48'(M), 48'h1E);
        chk("a7_p", P, 48'hFE6FFFEC0BB1);
        chk("a7_pcout", PCOUT, 48'hFE6FFFEC0BB1);
        chk("a7_carryout", 48'(CARRYOUT), 48'd1);
        chk("a7_carryoutf", 48'(CARRYOUTF), 48'd1);
        chk("model_a7_p", eP[ek], 48'hFE6FFFEC0BB1);

        OPMODE = 8'h09; A = 18'd3; B = 18'd4; PCIN = 48'd0;
        for (int i = 0; i < 6; i++) tick();
        RSTP = 1'b1;
        tick();
        RSTP = 1'b0;
        chk("rstp_p", P, 48'd0);
        chk("rstp_carryout", 48'(CARRYOUT), 48'd0);
        chk("rstp_m", 48'(M), 48'd12);
        tick();
        chk("rstp_resume_p", P, 48'd12);
        chk("model_resume_p", eP[ek], 48'd12);

        sv_p = eP[ek]; sv_m = eM[ek]; sv_b = eB1[ek]; sv_cy = eCy[ek];
        set_ce(1'b0);
        for (int i = 0; i < 5; i++) begin
            rand_data();
            tick();
        end
        chk("hold_p", P, sv_p);
        chk("hold_m", 48'(M), 48'(sv_m));
        chk("hold_bcout", 48'(BCOUT), 48'(sv_b));
        chk("hold_carryout", 48'(CARRYOUT), 48'(sv_cy));

        set_rst(1'b1); rand_ce(); rand_data();
        tick();
        set_rst(1'b0); set_ce(1'b1);
        for (int i = 0; i < 600; i++) begin
            rand_data();
            set_rst(1'b0); set_ce(1'b1);
            if ($urandom_range(0, 99) == 0) begin
                set_rst(1'b1); rand_ce();
            end else begin
                RSTP = ($urandom_range(0, 24) == 0);
            end
            tick();
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
